// File: rtl/fb_pkg.sv
// Shared framebuffer definitions. The fill engine and the VGA reader both use them.
// Holds the fill FSM state type and the default framebuffer geometry.
package fb_pkg;

  // Default framebuffer geometry: 160x120 pixels, 16-bit words, row-major.
  localparam int unsigned FbWidth    = 160;
  localparam int unsigned FbHeight   = 120;
  localparam logic [15:0] FbBaseAddr = 16'h0000;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StWrite,
    StDone
  } fb_state_e;

endpackage

// File: rtl/fb_fill.sv
// Rectangle fill engine. It writes one colour word to every pixel of a rectangle
// in a row-major framebuffer RAM. The rectangle is clipped to the framebuffer edges.
//
// Ports:
//   clock, reset        single clock, asynchronous active-high reset
//   start               request a fill (accepted only when idle)
//   x0, y0, w, h        rectangle origin and size in pixels
//   color               word written to each pixel
//   address, data, wren RAM write port, one word per cycle with wren high
//   busy                high from the accepted start until done
//   done                one-cycle completion pulse
//   written             count of words written by the last or current fill
module fb_fill
  import fb_pkg::*;
#(
  parameter int unsigned FB_WIDTH  = FbWidth,
  parameter int unsigned FB_HEIGHT = FbHeight,
  parameter logic [15:0] BASE_ADDR = FbBaseAddr
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  x0,
  input  logic [7:0]  y0,
  input  logic [7:0]  w,
  input  logic [7:0]  h,
  input  logic [15:0] color,
  output logic [15:0] address,
  output logic [15:0] data,
  output logic        wren,
  output logic        busy,
  output logic        done,
  output logic [15:0] written
);

  localparam logic [15:0] FbW16 = 16'(FB_WIDTH);
  localparam logic [15:0] FbH16 = 16'(FB_HEIGHT);

  fb_state_e   state_q, state_d;
  logic [7:0]  x0_q, x0_d, y0_q, y0_d, w_q, w_d, h_q, h_d;
  logic [15:0] color_q, color_d;
  logic [7:0]  ew_q, ew_d, eh_q, eh_d;
  logic [7:0]  col_q, col_d, row_q, row_d;
  logic [15:0] row_base_q, row_base_d;
  logic [15:0] addr_q, addr_d, data_q, data_d;
  logic [15:0] written_q, written_d;

  // Clipping on the latched request. The remaining room is at most w here,
  // so it always fits in 8 bits when it is the chosen value.
  logic        off_screen;
  logic [15:0] room_x, room_y, row_base_c;
  logic [7:0]  ew_c, eh_c;

  always_comb begin
    off_screen = ({8'h00, x0_q} >= FbW16) || ({8'h00, y0_q} >= FbH16);
    room_x     = FbW16 - {8'h00, x0_q};
    room_y     = FbH16 - {8'h00, y0_q};
    ew_c       = 8'h00;
    eh_c       = 8'h00;
    if (!off_screen) begin
      ew_c = ({8'h00, w_q} < room_x) ? w_q : room_x[7:0];
      eh_c = ({8'h00, h_q} < room_y) ? h_q : room_y[7:0];
    end
    // The only multiply. It is evaluated once per fill, in SETUP.
    row_base_c = BASE_ADDR + 16'({8'h00, y0_q} * FbW16);
  end

  always_comb begin
    state_d    = state_q;
    x0_d       = x0_q;
    y0_d       = y0_q;
    w_d        = w_q;
    h_d        = h_q;
    color_d    = color_q;
    ew_d       = ew_q;
    eh_d       = eh_q;
    col_d      = col_q;
    row_d      = row_q;
    row_base_d = row_base_q;
    addr_d     = addr_q;
    data_d     = data_q;
    written_d  = written_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          x0_d      = x0;
          y0_d      = y0;
          w_d       = w;
          h_d       = h;
          color_d   = color;
          written_d = 16'h0000;
          state_d   = StSetup;
        end
      end
      StSetup: begin
        ew_d       = ew_c;
        eh_d       = eh_c;
        col_d      = 8'h00;
        row_d      = 8'h00;
        row_base_d = row_base_c;
        if (ew_c == 8'h00 || eh_c == 8'h00) begin
          state_d = StDone;
        end else begin
          // Address and data are loaded only when a write follows, so they
          // hold their previous values through an empty fill.
          addr_d  = row_base_c + {8'h00, x0_q};
          data_d  = color_q;
          state_d = StWrite;
        end
      end
      StWrite: begin
        written_d = written_q + 16'h0001;
        if (col_q == ew_q - 8'h01) begin
          if (row_q == eh_q - 8'h01) begin
            state_d = StDone;
          end else begin
            col_d      = 8'h00;
            row_d      = row_q + 8'h01;
            row_base_d = row_base_q + FbW16;
            addr_d     = row_base_q + FbW16 + {8'h00, x0_q};
          end
        end else begin
          col_d  = col_q + 8'h01;
          addr_d = addr_q + 16'h0001;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      x0_q       <= 8'h00;
      y0_q       <= 8'h00;
      w_q        <= 8'h00;
      h_q        <= 8'h00;
      color_q    <= 16'h0000;
      ew_q       <= 8'h00;
      eh_q       <= 8'h00;
      col_q      <= 8'h00;
      row_q      <= 8'h00;
      row_base_q <= 16'h0000;
      addr_q     <= 16'h0000;
      data_q     <= 16'h0000;
      written_q  <= 16'h0000;
    end else begin
      state_q    <= state_d;
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      w_q        <= w_d;
      h_q        <= h_d;
      color_q    <= color_d;
      ew_q       <= ew_d;
      eh_q       <= eh_d;
      col_q      <= col_d;
      row_q      <= row_d;
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      written_q  <= written_d;
    end
  end

  // Decoded from the state register, so an asynchronous reset clears them at once.
  always_comb begin
    wren    = (state_q == StWrite);
    busy    = (state_q == StSetup) || (state_q == StWrite);
    done    = (state_q == StDone);
    address = addr_q;
    data    = data_q;
    written = written_q;
  end

endmodule

// File: tb/tb_fb_fill.sv
module tb_fb_fill;

  localparam int W    = 160;
  localparam int H    = 120;
  localparam int BASE = 0;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  x0, y0, w, h;
  logic [15:0] color;
  logic [15:0] address, data, written;
  logic        wren, busy, done;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];
  logic [15:0] hold_addr = 16'h0000;
  logic [15:0] hold_data = 16'h0000;

  fb_fill #(
    .FB_WIDTH (W),
    .FB_HEIGHT(H),
    .BASE_ADDR(16'h0000)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .x0     (x0),
    .y0     (y0),
    .w      (w),
    .h      (h),
    .color  (color),
    .address(address),
    .data   (data),
    .wren   (wren),
    .busy   (busy),
    .done   (done),
    .written(written)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, got, got, exp, exp,
               $time);
    end
  endtask

  // Reference: the clipped rectangle enumerated directly in row-major order.
  task automatic build_model(input int fx0, input int fy0, input int fw, input int fh);
    int ew, eh;
    exp_q.delete();
    if (fx0 >= W || fy0 >= H) begin
      ew = 0;
      eh = 0;
    end else begin
      ew = (fw < W - fx0) ? fw : W - fx0;
      eh = (fh < H - fy0) ? fh : H - fy0;
    end
    for (int r = 0; r < eh; r++)
      for (int c = 0; c < ew; c++) exp_q.push_back(16'(BASE + (fy0 + r) * W + fx0 + c));
  endtask

  // One complete fill. inject > 0 pulses a conflicting start at that sample index.
  // imm = 1 raises start in the current cycle, which gives back-to-back operation.
  task automatic run_fill(input int fx0, input int fy0, input int fw, input int fh,
                          input logic [15:0] fc, input int inject_req, input bit imm,
                          output int n_obs, output int first_a, output int last_a);
    logic [15:0] got_a[$];
    logic [15:0] got_d[$];
    int idx, first_idx, done_idx, exp_n, exp_done, inject;
    bit seen;
    build_model(fx0, fy0, fw, fh);
    exp_n    = exp_q.size();
    exp_done = (exp_n == 0) ? 2 : 2 + exp_n;
    inject   = inject_req;
    if (inject > exp_done) inject = exp_done;
    if (inject == 1) inject = 2;
    if (!imm) @(negedge clock);
    start = 1'b1;
    x0 = 8'(fx0); y0 = 8'(fy0); w = 8'(fw); h = 8'(fh); color = fc;
    idx = 0; seen = 0; first_idx = -1; done_idx = -1;
    while (!seen && idx < 4000) begin
      @(negedge clock);
      idx++;
      if (idx == 1) begin
        start = 1'b0;
        x0 = 8'($urandom); y0 = 8'($urandom); w = 8'($urandom); h = 8'($urandom);
        color = 16'($urandom);
        chk("setup_busy", busy, 1);
        chk("setup_wren", wren, 0);
      end
      if (inject > 0 && idx == inject) begin
        start = 1'b1; color = ~fc; x0 = 8'd0; y0 = 8'd0; w = 8'd1; h = 8'd1;
      end else if (inject > 0 && idx == inject + 1) begin
        start = 1'b0;
      end
      if (wren) begin
        got_a.push_back(address);
        got_d.push_back(data);
        if (first_idx < 0) first_idx = idx;
      end
      if (done) begin
        seen = 1;
        done_idx = idx;
      end
    end
    if (exp_n > 0) begin
      hold_addr = exp_q[exp_n-1];
      hold_data = fc;
    end
    if (!seen) begin
      chk("done_timeout", 0, 1);
    end else begin
      chk("done_cycle", done_idx, exp_done);
      chk("written_at_done", written, exp_n);
      chk("busy_at_done", busy, 0);
      chk("addr_hold_at_done", address, hold_addr);
      chk("data_hold_at_done", data, hold_data);
    end
    chk("write_count", got_a.size(), exp_n);
    if (exp_n > 0) chk("first_wren_cycle", first_idx, 2);
    for (int i = 0; i < got_a.size() && i < exp_n; i++) begin
      chk("write_addr", got_a[i], exp_q[i]);
      chk("write_data", got_d[i], fc);
    end
    @(negedge clock);
    start = 1'b0;
    chk("done_pulse_width", done, 0);
    chk("idle_busy", busy, 0);
    chk("written_hold", written, exp_n);
    n_obs   = got_a.size();
    first_a = (got_a.size() > 0) ? int'(got_a[0]) : -1;
    last_a  = (got_a.size() > 0) ? int'(got_a[got_a.size()-1]) : -1;
  endtask

  typedef struct {
    int          x0, y0, w, h;
    logic [15:0] color;
    int          exp_n, exp_first, exp_last;
  } vec_t;

  initial begin
    vec_t vecs[8];
    int n, fa, la, cnt, bad;
    vecs[0] = '{2, 3, 4, 2, 16'h0F00, 8, 482, 645};
    vecs[1] = '{5, 5, 0, 7, 16'h1111, 0, -1, -1};
    vecs[2] = '{5, 5, 7, 0, 16'h2222, 0, -1, -1};
    vecs[3] = '{158, 119, 10, 10, 16'h3333, 2, 19198, 19199};
    vecs[4] = '{200, 10, 5, 5, 16'h4444, 0, -1, -1};
    vecs[5] = '{10, 120, 5, 5, 16'h5555, 0, -1, -1};
    vecs[6] = '{0, 0, 1, 1, 16'h6666, 1, 0, 0};
    vecs[7] = '{159, 0, 5, 1, 16'h7777, 1, 159, 159};

    reset = 1'b1; start = 1'b0;
    x0 = 8'd0; y0 = 8'd0; w = 8'd0; h = 8'd0; color = 16'h0000;
    repeat (3) @(negedge clock);
    chk("rst_wren", wren, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_address", address, 0);
    chk("rst_data", data, 0);
    chk("rst_written", written, 0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_fill(vecs[i].x0, vecs[i].y0, vecs[i].w, vecs[i].h, vecs[i].color, 0, 0, n, fa, la);
      chk("vec_count", n, vecs[i].exp_n);
      if (vecs[i].exp_n > 0) begin
        chk("vec_first_addr", fa, vecs[i].exp_first);
        chk("vec_last_addr", la, vecs[i].exp_last);
      end
    end

    // Conflicting start during WRITE, then during DONE; both must be ignored.
    run_fill(20, 30, 6, 3, 16'h1234, 5, 0, n, fa, la);
    run_fill(40, 50, 2, 2, 16'hBEEF, 99, 0, n, fa, la);
    // Back-to-back: new start in the idle cycle right after DONE.
    run_fill(1, 1, 3, 2, 16'hCAFE, 0, 1, n, fa, la);

    // Reset after the third write of a 4x4 fill.
    @(negedge clock);
    start = 1'b1; x0 = 8'd10; y0 = 8'd10; w = 8'd4; h = 8'd4; color = 16'hABCD;
    @(negedge clock);
    start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40 && cnt < 3; i++) begin
      @(negedge clock);
      if (wren) cnt++;
    end
    chk("pre_reset_writes", cnt, 3);
    @(posedge clock);
    #1 reset = 1'b1;
    #1;
    chk("abort_wren", wren, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_address", address, 0);
    chk("abort_written", written, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    hold_addr = 16'h0000;
    hold_data = 16'h0000;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (wren || done || busy) bad++;
    end
    chk("post_abort_quiet", bad, 0);
    run_fill(0, 5, 3, 2, 16'h0A0A, 0, 0, n, fa, la);

    // Randomized fills against the reference model.
    for (int i = 0; i < 30; i++) begin
      int rx, ry, rw, rh, inj;
      rx  = $urandom_range(0, 175);
      ry  = $urandom_range(0, 125);
      rw  = $urandom_range(0, 40);
      rh  = $urandom_range(0, 10);
      if ($urandom_range(0, 4) == 0) begin
        rw = $urandom_range(0, 255);
        rh = $urandom_range(0, 6);
      end
      inj = ($urandom_range(0, 2) == 0) ? $urandom_range(2, 60) : 0;
      run_fill(rx, ry, rw, rh, 16'($urandom), inj, 1'($urandom_range(0, 1)), n, fa, la);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fb_fill.md
FB_FILL -- requirements
Module: fb_fill

Interface
REQ-001 SHALL have parameter FB_WIDTH, default 160, pixels (16-bit words) per framebuffer line.
REQ-002 SHALL have parameter FB_HEIGHT, default 120, lines in framebuffer.
REQ-003 SHALL have parameter BASE_ADDR, default 16'h0000, RAM word address of pixel (0,0).
REQ-004 SHALL have port clock  input  1  single clock for the block; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  request to fill one rectangle; sampled each rising edge.
REQ-007 SHALL have ports x0, y0  input  8 each  top-left pixel of the rectangle.
REQ-008 SHALL have ports w, h  input  8 each  rectangle width and height in pixels.
REQ-009 SHALL have port color  input  16  word written to every pixel.
REQ-010 SHALL have port address  output  16  RAM write address (connects to the RAM write port).
REQ-011 SHALL have port data  output  16  RAM write data.
REQ-012 SHALL have port wren  output  1  RAM write enable, one word per asserted cycle.
REQ-013 SHALL have port busy  output  1  high from accepted start until done.
REQ-014 SHALL have port done  output  1  one-cycle pulse at fill completion.
REQ-015 SHALL have port written  output  16  count of words written by the last or current fill.

Function
REQ-016 SHALL implement FSM states IDLE, SETUP, WRITE, DONE.
REQ-017 IDLE: start=1 SHALL latch x0, y0, w, h, color, clear written, and go to SETUP; busy rises the next cycle.
REQ-018 start while not IDLE SHALL be ignored; inputs change after acceptance SHALL not affect the fill in progress.
REQ-019 SETUP SHALL clip: ew = min(w, FB_WIDTH-x0), eh = min(h, FB_HEIGHT-y0); x0>=FB_WIDTH or y0>=FB_HEIGHT gives ew=eh=0.
REQ-020 SETUP SHALL go to DONE if ew==0 or eh==0 (no writes), otherwise to WRITE with row_base = BASE_ADDR + y0*FB_WIDTH.
REQ-021 First wren SHALL occur two cycles after the start-accepting edge (one SETUP cycle).
REQ-022 WRITE SHALL assert wren every cycle, with address = row_base + x0 + col, data = color, in row-major order, col 0..ew-1.
REQ-023 At col==ew-1 SHALL set col=0 and advance row_base by FB_WIDTH (add, no multiply in WRITE); after last pixel of row eh-1 go to DONE.
REQ-024 Address arithmetic SHALL be 16-bit modulo 2^16.
REQ-025 written SHALL increment once per wren cycle; final value SHALL equal ew*eh.
REQ-026 DONE SHALL assert done for exactly one cycle, deassert busy, and return to IDLE; start in DONE is ignored.
REQ-027 wren SHALL be 0 in all states other than WRITE; address and data SHALL hold last value when wren=0.
REQ-028 Back-to-back start is accepted in the IDLE cycle following DONE.

Reset
REQ-029 reset=1 SHALL immediately force IDLE, wren=0, busy=0, done=0, address=0, data=0, written=0.
REQ-030 reset mid-WRITE SHALL abort the fill with no further writes and no done pulse.

Structure
REQ-031 Shared package fb_pkg SHALL hold the FSM state typedef and default FB_WIDTH/FB_HEIGHT/BASE_ADDR constants, shared with the VGA reader.
REQ-032 No sub-module; clip computation and address counters SHALL be inside fb_fill.

Verification
REQ-033 x0=2,y0=3,w=4,h=2,color=16'h0F00 -> 8 writes at 482..485, 642..645; done one cycle after last write; written=8.
REQ-034 w=0 or h=0 -> no wren, done pulse 2 cycles after start, written=0.
REQ-035 x0=158,y0=119,w=10,h=10 -> clipped to 2 writes at 19198,19199; written=2.
REQ-036 x0=200 -> no writes, done pulse, written=0.
REQ-037 start pulsed during WRITE with different color -> ignored; all writes use original color.
REQ-038 reset asserted after 3rd write of 4x4 fill -> wren=0 immediately, no done, busy=0; next start fills normally.
